// File: rtl/stepgen_pkg.sv
// Shared definitions for the push-button step generator: FSM state encodings
// and the width helper used for the debounce and hold counters.
package stepgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_PRESS = 2'd2,
    ST_REL   = 2'd3
  } state_t;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/step_pulse_gen_sync2.sv
// Two-flop synchronizer bringing the raw push-button into the clk domain.
module sync2 (
  input  logic reset,
  input  logic clk,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Debounced push-button to one-cycle step pulse. Optional hold-to-repeat
// stepping is compiled in when STEP_AUTOREPEAT_EN is defined.
//
// state | meaning
// IDLE  | button released and stable
// ARM   | button seen high, counting stable samples before accepting
// PRESS | press accepted, step issued on entry
// REL   | button seen low, counting stable samples before accepting release
module step_pulse_gen
  import stepgen_pkg::*;
#(
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       step,
  output logic       btn_db,
  output logic [1:0] fsm_state
);

  localparam int CNT_W = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_step;
  logic             w_step_nxt;
  logic             w_btn_s;
  logic             w_rep_hit;

  sync2 u_sync (
    .reset (reset),
    .clk   (clk),
    .d     (btn_raw),
    .q     (w_btn_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = ST_ARM;
          w_cnt_nxt   = '0;
        end
      end
      ST_ARM: begin
        if (!w_btn_s) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_PRESS;
          w_step_nxt  = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_PRESS: begin
        if (!w_btn_s) begin
          w_state_nxt = ST_REL;
          w_cnt_nxt   = '0;
        end else begin
          w_step_nxt = w_rep_hit;
        end
      end
      ST_REL: begin
        if (w_btn_s) begin
          w_state_nxt = ST_PRESS;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Back-to-back steps would double-advance the downstream counter.
    if (r_step) w_step_nxt = 1'b0;
  end

`ifdef STEP_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] r_hold;
  logic             r_rep;

  assign w_rep_hit = (r_hold == (r_rep ? PERIOD_LAST : DELAY_LAST));

  // Hold time restarts whenever PRESS is left, even for a brief REL bounce.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
      r_rep  <= 1'b0;
    end else if (r_state == ST_PRESS && w_state_nxt == ST_PRESS) begin
      if (w_rep_hit) begin
        r_hold <= '0;
        r_rep  <= 1'b1;
      end else if (r_hold != CNT_MAX) begin
        r_hold <= r_hold + CNT_W'(1);
      end
    end else begin
      r_hold <= '0;
      r_rep  <= 1'b0;
    end
  end
`else
  assign w_rep_hit = 1'b0;
`endif

  // PRESS and REL are the only codes with the MSB set, so the level is a flop bit.
  assign btn_db    = r_state[1];
  assign step      = r_step;
  assign fsm_state = r_state;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5;
// expectations follow STEP_AUTOREPEAT_EN when it is defined for the build.
module tb_step_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef STEP_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_raw;
  logic       step;
  logic       btn_db;
  logic [1:0] fsm_state;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string      nm;
    logic       btn;
    logic       stp;
    logic       db;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  step_pulse_gen #(
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .step      (step),
    .btn_db    (btn_db),
    .fsm_state (fsm_state)
  );

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_all(input string nm, input logic s, input logic d, input logic [1:0] st);
    chk({nm, ".step"},  {1'b0, step},   {1'b0, s});
    chk({nm, ".btn_db"}, {1'b0, btn_db}, {1'b0, d});
    chk({nm, ".state"}, fsm_state, st);
  endtask

  task automatic add(input string nm, input logic b, input logic s, input logic d,
                     input logic [1:0] st);
    vec_t v;
    v.nm = nm; v.btn = b; v.stp = s; v.db = d; v.st = st;
    vecs.push_back(v);
  endtask

  // Clean press from IDLE: 2 sync cycles, 1 to enter ARM, DB-1 counts, then PRESS.
  task automatic add_press(input string nm);
    for (int i = 0; i < 7; i++)
      add($sformatf("%s%0d", nm, i), 1'b1, i == 6, i == 6,
          (i < 2) ? 2'd0 : (i < 6) ? 2'd1 : 2'd2);
  endtask

  task automatic add_release(input string nm);
    for (int i = 0; i < 7; i++)
      add($sformatf("%s%0d", nm, i), 1'b0, 1'b0, i < 6,
          (i < 2) ? 2'd2 : (i < 6) ? 2'd3 : 2'd0);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    btn_raw = v.btn;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk_all(e.nm, e.stp, e.db, e.st);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int w;
    w = 0;
    while (fsm_state != 2'd0 && w < 20) begin
      tick();
      w++;
    end
    chk(nm, fsm_state, 2'd0);
  endtask

  task automatic hold_check(input string nm, input int n);
    logic ex;
    for (int k = 1; k <= n; k++) begin
      tick();
      ex = AUTO && (k >= RD) && ((k - RD) % RP == 0);
      chk($sformatf("%s_k%0d", nm, k), {1'b0, step}, {1'b0, ex});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset   = 1'b0;
    btn_raw = 1'b0;
    #1;
    chk_all("reset", 1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    add("idle0", 1'b0, 1'b0, 1'b0, 2'd0);
    add("idle1", 1'b0, 1'b0, 1'b0, 2'd0);
    add_press("press");
    for (int i = 0; i < 3; i++) add($sformatf("hold%0d", i), 1'b1, 1'b0, 1'b1, 2'd2);
    add_release("rel");
    add("idle2", 1'b0, 1'b0, 1'b0, 2'd0);
    add("idle3", 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 7; i++)
      add($sformatf("bounce%0d", i), i < 3, 1'b0, 1'b0,
          (i >= 2 && i <= 4) ? 2'd1 : 2'd0);
    add("idle4", 1'b0, 1'b0, 1'b0, 2'd0);
    add("idle5", 1'b0, 1'b0, 1'b0, 2'd0);
    add_press("gpress");
    add("ghold0", 1'b1, 1'b0, 1'b1, 2'd2);
    add("ghold1", 1'b1, 1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 6; i++)
      add($sformatf("glitch%0d", i), i >= 2, 1'b0, 1'b1,
          (i == 2 || i == 3) ? 2'd3 : 2'd2);
    add_release("grel");
    add("idle6", 1'b0, 1'b0, 1'b0, 2'd0);
    add("idle7", 1'b0, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset during ARM with cnt=2, button held through release.
    @(negedge clk);
    btn_raw = 1'b1;
    repeat (5) tick();
    chk("rst_arm.state", fsm_state, 2'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_all("rst_assert", 1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    chk_all("rst_held", 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("rst_rel_k%0d.step", k), {1'b0, step}, {1'b0, k == 7});
      if (k == 7) chk_all("rst_rel_press", 1'b1, 1'b1, 2'd2);
    end
    @(negedge clk);
    btn_raw = 1'b0;
    wait_idle("rst_rel_idle");

    // Long hold: auto-repeat cadence, then a REL bounce restarts the hold time.
    @(negedge clk);
    btn_raw = 1'b1;
    w = 0;
    do begin
      tick();
      w++;
    end while (step !== 1'b1 && w < 20);
    chk("ar_first.step", {1'b0, step}, 2'd1);
    chk("ar_first.lat", w[1:0] == 2'(7 % 4) && w == 7 ? 2'd1 : 2'd0, 2'd1);
    hold_check("ar", 50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      btn_raw = (i >= 2);
      tick();
      chk_all($sformatf("ar_glitch%0d", i), 1'b0, 1'b1,
              (i == 2 || i == 3) ? 2'd3 : 2'd2);
    end
    hold_check("ar_reentry", 25);
    @(negedge clk);
    btn_raw = 1'b0;
    wait_idle("ar_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
